jt08_adpcmb_dec: RTL and testbench
==================================

# jt08_adpcmb_dec

ADPCM-B nibble decoder and rate generator that sits directly upstream of the ADPCM-B interpolator. Fetches 4-bit ADPCM codes from sample ROM, decodes them one sample ahead, and accumulates the delta-N rate at 55 kHz. On each rate overflow it presents the new sample `pcmdec` plus the magnitude and sign of the sample-to-sample difference (`deltax`, `dsign`) and raises `adv` for the interpolator.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `cen`  in  1  8 MHz clock enable
- `cen55`  in  1  55 kHz enable; only ever high in cycles where `cen` is high
- `on`  in  1  channel enable level; a rising edge starts playback
- `rep`  in  1  repeat on end of sample
- `deltan`  in  16  playback rate; `adv` frequency = 55 kHz × `deltan`/65536
- `addr_start`  in  16  first byte = {`addr_start`, 8'h00}
- `addr_end`  in  16  last byte = {`addr_end`, 8'hFF}, inclusive
- `rom_addr`  out  24  byte address
- `rom_cs`  out  1  read request, held until `rom_ok`
- `rom_data`  in  8  byte read
- `rom_ok`  in  1  `rom_data` valid; sampled on `cen`
- `adv`  out  1  advance; changes only on `cen55` cycles
- `pcmdec`  out  16 signed  current decoded sample s_k
- `deltax`  out  16  |s_k − s_{k−1}|, saturated to 16'hFFFF
- `dsign`  out  1  1 when s_k < s_{k−1}
- `flag`  out  1  end of sample reached with `rep` = 0; sticky until the next start
- `busy`  out  1  playback active

## Operation
- Internal state:
  - `x` (16-bit signed accumulator)
  - `delta` (15-bit step, range 127..24576)
  - `acc` (16-bit phase accumulator)
  - nibble pointer: byte address plus high/low select; high nibble first
  - lookahead sample `xn`
- Start (rising edge of `on`):
  - `x` = 0, `delta` = 127, `acc` = 0, `pcmdec` = 0
  - `flag` = 0, `busy` = 1
  - address = `addr_start`, high nibble
  - FSM → FETCH
- `on` = 0: FSM → IDLE, `busy` = 0, `rom_cs` = 0, `adv` = 0. Outputs hold their values.
- FSM states (all advance on `cen` only):
  - IDLE: wait for start.
  - FETCH: `rom_cs` = 1 until `rom_ok`; latch byte. If the current byte is already latched (low nibble pending), skip directly to DECODE.
  - DECODE, 2 cycles, with n = code[2:0]:
    - d = ((2n+1)·`delta`) >> 3, 19-bit product
    - `xn` = sat16(`x` ± d); minus when code[3] = 1
    - `delta` = clamp((`delta`·T[n]) >> 6, 127, 24576), where T = {57,57,57,57,77,102,128,153}
  - READY: lookahead valid; wait for commit.
- Rate and commit, on each `cen55`:
  - {carry, `acc`} = `acc` + `deltan`.
  - If carry and state READY:
    - `adv` <= 1
    - `dsign` <= (`xn` < `x`)
    - `deltax` <= sat(|`xn` − `x`|), 17-bit difference
    - `pcmdec` <= `xn`, `x` <= `xn`
    - advance nibble pointer; FSM → FETCH
  - Otherwise `adv` <= 0.
- Carry while not in READY: carry is held pending and committed at the first `cen55` in READY. No carry is lost; at most one is held.
- End of sample: after the low nibble of byte {`addr_end`, FF} commits:
  - `rep` = 1: reload the start address, `x` = 0, `delta` = 127, keep `pcmdec`, continue.
  - `rep` = 0: `flag` = 1, `busy` = 0, FSM → IDLE.
- Address wraps modulo 2^24.

## Timing
- Reset values: `adv`, `rom_cs`, `flag`, `busy` = 0; `pcmdec`, `deltax`, `rom_addr` = 0; `dsign` = 0. Internally `delta` = 127, `acc` = 0, FSM = IDLE.
- `adv` is registered and stays high exactly one `cen55` period. The downstream stage samples it on the following `cen55`.
- `pcmdec`, `deltax` and `dsign` change only in the same cycle `adv` rises, and are stable for ≥ 3 `cen` afterwards.
- Lookahead latency from commit to READY: 1 FETCH + ROM wait + 2 DECODE `cen` cycles. It must stay below 144 `cen`, one 55 kHz period.
- Reset mid-playback wins over all else. A rising edge of `on` in the same cycle as a commit takes priority as a start.

## Test plan
- Reset: hold `rst_n` = 0 for 4 clocks → all outputs 0, `busy` = 0.
- Rate: `deltan` = 16'h8000, ROM always ready → `adv` high on every 2nd `cen55` period. With `deltan` = 16'hFFFF → high on 65535 of 65536 periods.
- Decode: byte 8'h70 after start → first commit `pcmdec` = 238, `deltax` = 238, `dsign` = 0. Second commit `pcmdec` = 275, `deltax` = 37, `dsign` = 0; internal `delta` = 269.
- Negative: byte 8'hF8 → `pcmdec` = −238, `dsign` = 1, `deltax` = 238. Next commit: x = −238 − 37 = −275.
- Saturation: 200 bytes of 8'h77 → `pcmdec` holds 32767, `delta` holds 24576, `deltax` = 0 once clamped.
- End/repeat and ROM stall:
  - `addr_start` = `addr_end` = 0, `rep` = 0 → 512 commits, then `flag` = 1, `busy` = 0, no further `adv`.
  - Same with `rep` = 1 → address 0 refetched and x restarts from 0.
  - `rom_ok` delayed 100 `cen` → pending carry preserved and `adv` issued late.

Source files
------------

// File: rtl/jt08_adpcmb_dec.sv
// ADPCM-B nibble decoder with 55 kHz delta-N rate generator.
// Decodes one sample ahead of the interpolator and commits it on each rate overflow.
//
// state   | meaning
// S_IDLE  | waiting for a rising edge of i_on
// S_FETCH | requesting the byte for the current nibble (skipped if already latched)
// S_DEC1  | step and delta products
// S_DEC2  | saturate lookahead sample, clamp new step
// S_READY | lookahead valid, waiting for a rate carry
module jt08_adpcmb_dec (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cen,
    input  logic               i_cen55,
    input  logic               i_on,
    input  logic               i_rep,
    input  logic [15:0]        i_deltan,
    input  logic [15:0]        i_addr_start,
    input  logic [15:0]        i_addr_end,
    output logic [23:0]        o_rom_addr,
    output logic               o_rom_cs,
    input  logic [7:0]         i_rom_data,
    input  logic               i_rom_ok,
    output logic               o_adv,
    output logic signed [15:0] o_pcmdec,
    output logic [15:0]        o_deltax,
    output logic               o_dsign,
    output logic               o_flag,
    output logic               o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DEC1, S_DEC2, S_READY} state_t;
    state_t r_state, w_next;

    logic               r_on_d, r_nib, r_bvalid, r_pend;
    logic               r_adv, r_ds, r_flag, r_busy;
    logic signed [15:0] r_x, r_xn, r_pcm;
    logic [14:0]        r_delta;
    logic [15:0]        r_acc, r_d, r_dx;
    logic [16:0]        r_dmul;
    logic [23:0]        r_addr;
    logic [7:0]         r_byte;

    logic               w_start, w_carry, w_commit, w_last;
    logic [3:0]         w_code;
    logic [2:0]         w_n;
    logic [7:0]         w_tmul;
    logic [18:0]        w_prod;
    logic [22:0]        w_dprod;
    logic [15:0]        w_d;
    logic [16:0]        w_dm;
    logic [17:0]        w_sum_x;
    logic [15:0]        w_xsat;
    logic [14:0]        w_dclamp;
    logic [16:0]        w_sum_acc, w_diff, w_abs;

    assign w_start   = i_on & ~r_on_d;
    assign w_code    = r_nib ? r_byte[3:0] : r_byte[7:4];
    assign w_n       = w_code[2:0];
    assign w_prod    = {15'd0, w_n, 1'b1} * {4'd0, r_delta};
    assign w_dprod   = {8'd0, r_delta} * {15'd0, w_tmul};
    assign w_d       = 16'(w_prod >> 3);
    assign w_dm      = 17'(w_dprod >> 6);

    always_comb begin
        w_tmul = 8'd57;
        case (w_n)
            3'd4:    w_tmul = 8'd77;
            3'd5:    w_tmul = 8'd102;
            3'd6:    w_tmul = 8'd128;
            3'd7:    w_tmul = 8'd153;
            default: w_tmul = 8'd57;
        endcase
    end

    // 18 bits hold any x +/- d before saturation
    assign w_sum_x  = w_code[3] ? ({{2{r_x[15]}}, r_x} - {2'b00, r_d})
                                : ({{2{r_x[15]}}, r_x} + {2'b00, r_d});
    assign w_xsat   = (w_sum_x[17:15] == 3'b000 || w_sum_x[17:15] == 3'b111) ? w_sum_x[15:0]
                    : (w_sum_x[17] ? 16'h8000 : 16'h7FFF);
    assign w_dclamp = (r_dmul < 17'd127)   ? 15'd127
                    : (r_dmul > 17'd24576) ? 15'd24576 : r_dmul[14:0];

    assign w_diff    = {r_xn[15], r_xn} - {r_x[15], r_x};
    assign w_abs     = w_diff[16] ? (17'd0 - w_diff) : w_diff;
    assign w_sum_acc = {1'b0, r_acc} + {1'b0, i_deltan};
    assign w_carry   = i_cen55 & r_busy & w_sum_acc[16];
    assign w_commit  = i_cen55 & i_on & ~w_start & (r_state == S_READY) & (w_carry | r_pend);
    assign w_last    = r_nib & (r_addr == {i_addr_end, 8'hFF});

    always_comb begin
        w_next = r_state;
        if (!i_on)
            w_next = S_IDLE;
        else if (w_start)
            w_next = S_FETCH;
        else if (w_commit)
            w_next = (w_last && !i_rep) ? S_IDLE : S_FETCH;
        else if (i_cen) begin
            case (r_state)
                S_FETCH: if (r_bvalid || i_rom_ok) w_next = S_DEC1;
                S_DEC1:  w_next = S_DEC2;
                S_DEC2:  w_next = S_READY;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_on_d   <= 1'b0;
            r_x      <= '0;
            r_xn     <= '0;
            r_pcm    <= '0;
            r_delta  <= 15'd127;
            r_acc    <= '0;
            r_addr   <= '0;
            r_nib    <= 1'b0;
            r_bvalid <= 1'b0;
            r_byte   <= '0;
            r_pend   <= 1'b0;
            r_d      <= '0;
            r_dmul   <= '0;
            r_adv    <= 1'b0;
            r_dx     <= '0;
            r_ds     <= 1'b0;
            r_flag   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_on_d <= i_on;
            if (w_start) begin
                r_x      <= '0;
                r_pcm    <= '0;
                r_delta  <= 15'd127;
                r_acc    <= '0;
                r_addr   <= {i_addr_start, 8'h00};
                r_nib    <= 1'b0;
                r_bvalid <= 1'b0;
                r_pend   <= 1'b0;
                r_adv    <= 1'b0;
                r_flag   <= 1'b0;
                r_busy   <= 1'b1;
            end else if (!i_on) begin
                r_busy <= 1'b0;
                r_adv  <= 1'b0;
                r_pend <= 1'b0;
            end else begin
                if (i_cen55) begin
                    r_adv <= w_commit;
                    if (r_busy) r_acc <= w_sum_acc[15:0];
                end
                // a carry that arrives while still decoding waits here
                if (w_commit)     r_pend <= r_pend & w_carry;
                else if (w_carry) r_pend <= 1'b1;
                if (w_commit) begin
                    r_pcm <= r_xn;
                    r_x   <= r_xn;
                    r_ds  <= w_diff[16];
                    r_dx  <= w_abs[16] ? 16'hFFFF : w_abs[15:0];
                    if (w_last) begin
                        if (i_rep) begin
                            r_addr   <= {i_addr_start, 8'h00};
                            r_nib    <= 1'b0;
                            r_bvalid <= 1'b0;
                            r_x      <= '0;
                            r_delta  <= 15'd127;
                        end else begin
                            r_flag <= 1'b1;
                            r_busy <= 1'b0;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_nib <= ~r_nib;
                        if (r_nib) begin
                            r_addr   <= r_addr + 24'd1;
                            r_bvalid <= 1'b0;
                        end
                    end
                end
                if (i_cen) begin
                    case (r_state)
                        S_FETCH: if (!r_bvalid && i_rom_ok) begin
                            r_byte   <= i_rom_data;
                            r_bvalid <= 1'b1;
                        end
                        S_DEC1: begin
                            r_d    <= w_d;
                            r_dmul <= w_dm;
                        end
                        S_DEC2: begin
                            r_xn    <= w_xsat;
                            r_delta <= w_dclamp;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_rom_addr = r_addr;
    assign o_rom_cs   = (r_state == S_FETCH) & ~r_bvalid;
    assign o_adv      = r_adv;
    assign o_pcmdec   = r_pcm;
    assign o_deltax   = r_dx;
    assign o_dsign    = r_ds;
    assign o_flag     = r_flag;
    assign o_busy     = r_busy;
endmodule

// File: tb/tb_jt08_adpcmb_dec.sv
// Bench for jt08_adpcmb_dec: ROM responder, cen/cen55 generator and a commit scoreboard
// fed by a behavioural decoder model.
module tb_jt08_adpcmb_dec;
    logic clk = 0, rst_n = 0, cen = 0, cen55 = 0, on = 0, rep = 0;
    logic [15:0] deltan = 0, addr_start = 0, addr_end = 0;
    logic [7:0]  rom_data = 0;
    logic        rom_ok = 0;
    logic [23:0] o_rom_addr;
    logic        o_rom_cs, o_adv, o_dsign, o_flag, o_busy;
    logic signed [15:0] o_pcmdec;
    logic [15:0] o_deltax;

    typedef struct {
        logic signed [15:0] pcm;
        logic [15:0]        dx;
        logic               ds;
    } exp_t;

    int checks = 0, errors = 0;
    int p55 = 0, fetch0 = 0, wcnt = 0, div = 7;
    int stall_addr = -1, stall_lat = 100;
    bit cen_ph = 0;
    logic [7:0] rom [0:1023];
    exp_t sb[$];
    int   ctimes[$];
    exp_t e;

    jt08_adpcmb_dec dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_cen55(cen55), .i_on(on), .i_rep(rep),
        .i_deltan(deltan), .i_addr_start(addr_start), .i_addr_end(addr_end),
        .o_rom_addr(o_rom_addr), .o_rom_cs(o_rom_cs), .i_rom_data(rom_data), .i_rom_ok(rom_ok),
        .o_adv(o_adv), .o_pcmdec(o_pcmdec), .o_deltax(o_deltax), .o_dsign(o_dsign),
        .o_flag(o_flag), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // cen every other clock, cen55 every 8th cen; ROM answers after 1 cen (or stall_lat)
    always @(posedge clk) begin
        #3;
        cen_ph = ~cen_ph;
        cen    = cen_ph;
        if (cen_ph) begin
            div   = (div == 7) ? 0 : div + 1;
            cen55 = (div == 0);
        end else cen55 = 0;
        if (!o_rom_cs) begin
            rom_ok = 0;
            wcnt   = 0;
        end else begin
            rom_data = rom[o_rom_addr[9:0]];
            rom_ok   = (wcnt >= ((int'(o_rom_addr[9:0]) == stall_addr) ? stall_lat : 1));
            if (cen && !rom_ok) wcnt++;
            if (cen && rom_ok && o_rom_addr == 24'd0) fetch0++;
        end
    end

    always @(posedge clk) begin
        if (cen55) begin
            p55++;
            #1;
            if (o_adv === 1'b1) begin
                ctimes.push_back(p55);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL adv_unexpected: adv=1 at period %0d, required no advance", p55);
                end else begin
                    e = sb.pop_front();
                    if (o_pcmdec !== e.pcm || o_deltax !== e.dx || o_dsign !== e.ds) begin
                        errors++;
                        $display("FAIL sample: got pcmdec=%0d deltax=%0d dsign=%0d, required pcmdec=%0d deltax=%0d dsign=%0d",
                                 o_pcmdec, o_deltax, o_dsign, e.pcm, e.dx, e.ds);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int pcm, input int dx, input bit ds);
        exp_t r;
        r.pcm = 16'(pcm);
        r.dx  = 16'(dx);
        r.ds  = ds;
        return r;
    endfunction

    function automatic int tval(input int n);
        case (n)
            4: return 77;
            5: return 102;
            6: return 128;
            7: return 153;
            default: return 57;
        endcase
    endfunction

    task automatic push_diff(input int xp, input int xn);
        int ad;
        ad = (xn > xp) ? xn - xp : xp - xn;
        if (ad > 65535) ad = 65535;
        sb.push_back(mk(xn, ad, xn < xp));
    endtask

    task automatic model_push(input int first_b, input int last_b, input bit rp, input int n, input int skip);
        int x, dl, a, nb, code, nn, d, xn;
        logic [7:0] b;
        x = 0; dl = 127; a = first_b; nb = 0;
        for (int k = 0; k < n; k++) begin
            b    = rom[a & 1023];
            code = nb ? int'(b[3:0]) : int'(b[7:4]);
            nn   = code & 7;
            d    = ((2 * nn + 1) * dl) / 8;
            xn   = (code & 8) ? x - d : x + d;
            if (xn > 32767)  xn = 32767;
            if (xn < -32768) xn = -32768;
            dl = (dl * tval(nn)) / 64;
            if (dl < 127)   dl = 127;
            if (dl > 24576) dl = 24576;
            if (k >= skip) push_diff(x, xn);
            x = xn;
            if (nb == 1 && a == last_b) begin
                if (rp) begin a = first_b; nb = 0; x = 0; dl = 127; end
                else break;
            end else begin
                if (nb == 1) a++;
                nb = 1 - nb;
            end
        end
    endtask

    task automatic start_play(input logic [15:0] as, input logic [15:0] ae, input logic [15:0] dn,
                              input bit rp, output int s);
        @(negedge clk); on = 0;
        @(negedge clk);
        addr_start = as; addr_end = ae; deltan = dn; rep = rp;
        ctimes.delete();
        on = 1;
        @(posedge clk); #2;
        s = p55;
    endtask

    task automatic stop_play();
        @(negedge clk); on = 0;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic wait_drain(input int max_clk, output bit ok);
        ok = 0;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; on = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (o_adv !== 0 || o_busy !== 0 || o_flag !== 0 || o_rom_cs !== 0) begin errors++;
            $display("FAIL reset_ctrl: adv=%b busy=%b flag=%b rom_cs=%b, required all 0", o_adv, o_busy, o_flag, o_rom_cs); end
        checks++; if (o_pcmdec !== 16'sd0 || o_deltax !== 16'd0 || o_dsign !== 0) begin errors++;
            $display("FAIL reset_data: pcmdec=%0d deltax=%0d dsign=%b, required 0 0 0", o_pcmdec, o_deltax, o_dsign); end
        checks++; if (o_rom_addr !== 24'd0) begin errors++;
            $display("FAIL reset_addr: rom_addr=%h, required 000000", o_rom_addr); end
        rst_n = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rate();
        int s; bit ok;
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
        model_push(0, 1023, 0, 10, 0);
        start_play(16'd0, 16'd3, 16'h8000, 0, s);
        wait_drain(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rate_half_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
        checks++; if (ctimes.size() != 10) begin errors++;
            $display("FAIL rate_half_count: %0d commits, required 10", ctimes.size()); end
        for (int k = 0; k < ctimes.size(); k++) begin
            checks++; if (ctimes[k] != s + 2 * (k + 1)) begin errors++;
                $display("FAIL rate_half_time: commit %0d at period %0d, required %0d", k, ctimes[k] - s, 2 * (k + 1)); end
        end
        model_push(0, 1023, 0, 12, 0);
        start_play(16'd0, 16'd3, 16'hFFFF, 0, s);
        wait_drain(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rate_full_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
        for (int k = 0; k < ctimes.size(); k++) begin
            checks++; if (ctimes[k] != s + 2 + k) begin errors++;
                $display("FAIL rate_full_time: commit %0d at period %0d, required %0d", k, ctimes[k] - s, 2 + k); end
        end
    endtask

    task automatic test_decode();
        int s; bit ok;
        rom[0] = 8'h70; rom[1] = 8'h05;
        for (int i = 2; i < 8; i++) rom[i] = 8'($urandom_range(0, 255));
        sb.push_back(mk(238, 238, 0));
        sb.push_back(mk(275, 37, 0));
        sb.push_back(mk(308, 33, 0));
        model_push(0, 1023, 0, 8, 3);
        start_play(16'd0, 16'd3, 16'h8000, 0, s);
        wait_drain(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL decode_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
        checks++; if (o_busy !== 0) begin errors++; $display("FAIL decode_off_busy: busy=%b, required 0", o_busy); end
    endtask

    task automatic test_negative();
        int s; bit ok;
        rom[0] = 8'hF8;
        for (int i = 1; i < 8; i++) rom[i] = 8'($urandom_range(0, 255));
        sb.push_back(mk(-238, 238, 1));
        sb.push_back(mk(-275, 37, 1));
        model_push(0, 1023, 0, 6, 2);
        start_play(16'd0, 16'd3, 16'h8000, 0, s);
        wait_drain(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL negative_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
    endtask

    task automatic test_saturation();
        int s; bit ok;
        for (int i = 256; i < 456; i++) rom[i] = 8'h77;
        model_push(256, 1023, 0, 400, 0);
        start_play(16'd1, 16'd3, 16'hFFFF, 0, s);
        wait_drain(9000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: %0d pending, required 0", sb.size()); end
        checks++; if (o_pcmdec !== 16'sd32767 || o_deltax !== 16'd0 || o_dsign !== 0) begin errors++;
            $display("FAIL sat_final: pcmdec=%0d deltax=%0d dsign=%b, required 32767 0 0", o_pcmdec, o_deltax, o_dsign); end
        stop_play();
    endtask

    task automatic test_end();
        int s; bit ok;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
        model_push(0, 255, 0, 512, 0);
        start_play(16'd0, 16'd0, 16'hFFFF, 0, s);
        wait_drain(10000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL end_timeout: %0d pending, required 0", sb.size()); end
        repeat (320) @(negedge clk);
        checks++; if (o_flag !== 1 || o_busy !== 0 || o_rom_cs !== 0) begin errors++;
            $display("FAIL end_state: flag=%b busy=%b rom_cs=%b, required 1 0 0", o_flag, o_busy, o_rom_cs); end
        checks++; if (ctimes.size() != 512) begin errors++;
            $display("FAIL end_count: %0d commits, required 512", ctimes.size()); end
        checks++; if (ctimes.size() == 512 && ctimes[511] != s + 513) begin errors++;
            $display("FAIL end_last_time: last commit at period %0d, required 513", ctimes[511] - s); end
        stop_play();
    endtask

    task automatic test_repeat();
        int s; bit ok;
        model_push(0, 255, 1, 520, 0);
        fetch0 = 0;
        start_play(16'd0, 16'd0, 16'hFFFF, 1, s);
        checks++; if (o_flag !== 0 || o_busy !== 1) begin errors++;
            $display("FAIL repeat_start: flag=%b busy=%b, required 0 1", o_flag, o_busy); end
        wait_drain(10000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL repeat_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
        checks++; if (fetch0 != 2) begin errors++;
            $display("FAIL repeat_refetch: address 0 fetched %0d times, required 2", fetch0); end
        checks++; if (o_flag !== 0) begin errors++; $display("FAIL repeat_flag: flag=%b, required 0", o_flag); end
    endtask

    task automatic test_stall();
        int s; bit ok;
        for (int i = 0; i < 8; i++) rom[i] = 8'($urandom_range(0, 255));
        stall_addr = 1;
        model_push(0, 1023, 0, 4, 0);
        start_play(16'd0, 16'd3, 16'h2000, 0, s);
        wait_drain(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: %0d pending, required 0", sb.size()); end
        stop_play();
        stall_addr = -1;
        checks++; if (ctimes.size() != 4) begin errors++;
            $display("FAIL stall_count: %0d commits, required 4", ctimes.size()); end
        if (ctimes.size() == 4) begin
            checks++; if (ctimes[0] != s + 8 || ctimes[1] != s + 16) begin errors++;
                $display("FAIL stall_early: commits at %0d %0d, required 8 16", ctimes[0] - s, ctimes[1] - s); end
            checks++; if (ctimes[2] <= s + 24 || ctimes[2] >= s + 32) begin errors++;
                $display("FAIL stall_late: commit at %0d, required between 25 and 31", ctimes[2] - s); end
            checks++; if (ctimes[3] != s + 32) begin errors++;
                $display("FAIL stall_after: commit at %0d, required 32", ctimes[3] - s); end
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        rom[0] = 8'h77;
        model_push(0, 1023, 0, 2, 0);
        start_play(16'd0, 16'd3, 16'h8000, 0, s);
        wait_drain(1000, ok);
        checks++; if (!ok || o_busy !== 1) begin errors++;
            $display("FAIL midreset_pre: drained=%b busy=%b, required 1 1", ok, o_busy); end
        rst_n = 0; on = 0;
        @(negedge clk);
        checks++; if (o_busy !== 0 || o_pcmdec !== 16'sd0 || o_deltax !== 16'd0 || o_rom_cs !== 0 || o_adv !== 0) begin errors++;
            $display("FAIL midreset: busy=%b pcmdec=%0d deltax=%0d rom_cs=%b adv=%b, required 0 0 0 0 0",
                     o_busy, o_pcmdec, o_deltax, o_rom_cs, o_adv); end
        rst_n = 1;
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_rate();
        test_decode();
        test_negative();
        test_saturation();
        test_end();
        test_repeat();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
